// File: rtl/count_sequencer.sv
// Command sequencer around a WIDTH-bit cycle counter: start/pause/stop with
// one-shot or continuous mode, limit and mode latched when a run starts.
module count_sequencer #(
  parameter int unsigned WIDTH         = 10,
  parameter int unsigned DEFAULT_LIMIT = 999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             cont,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           cur_state, nxt_state;
  logic [WIDTH-1:0] q_r, q_n;
  logic [WIDTH-1:0] lim_r, lim_n;
  logic             mode_r, mode_n;
  logic             busy_r, busy_n;
  logic             done_r, done_n;
  logic             wrap_r, wrap_n;
  logic             advance;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= IDLE;
      q_r       <= '0;
      lim_r     <= WIDTH'(DEFAULT_LIMIT);
      mode_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      wrap_r    <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      q_r       <= q_n;
      lim_r     <= lim_n;
      mode_r    <= mode_n;
      busy_r    <= busy_n;
      done_r    <= done_n;
      wrap_r    <= wrap_n;
    end
  end

  // RUN and a resuming PAUSE share the same count/terminal action via 'advance'.
  always_comb begin
    nxt_state = cur_state;
    q_n       = q_r;
    lim_n     = lim_r;
    mode_n    = mode_r;
    done_n    = 1'b0;
    wrap_n    = 1'b0;
    advance   = 1'b0;

    case (cur_state)
      IDLE: begin
        q_n = '0;
        if (!stop && start) begin
          lim_n     = limit;
          mode_n    = cont;
          nxt_state = RUN;
        end
      end
      RUN, PAUSE: begin
        if (stop) begin
          nxt_state = IDLE;
          q_n       = '0;
        end else if (hold) begin
          nxt_state = PAUSE;
        end else begin
          nxt_state = RUN;
          advance   = 1'b1;
        end
      end
      DONE: begin
        if (stop) begin
          nxt_state = IDLE;
          q_n       = '0;
        end else if (start) begin
          lim_n     = limit;
          mode_n    = cont;
          q_n       = '0;
          nxt_state = RUN;
        end
      end
      default: begin
        nxt_state = IDLE;
        q_n       = '0;
      end
    endcase

    if (advance) begin
      if (q_r != lim_r) begin
        q_n = q_r + 1'b1;
      end else if (mode_r) begin
        q_n    = '0;
        wrap_n = 1'b1;
      end else begin
        nxt_state = DONE;
        done_n    = 1'b1;
      end
    end

    busy_n = (nxt_state == RUN) || (nxt_state == PAUSE);
  end

  always_comb begin
    q     = q_r;
    busy  = busy_r;
    done  = done_r;
    wrap  = wrap_r;
    state = cur_state;
  end

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer: directed vector table, scenario
// sequences and randomized commands against a behavioural model.
module tb_count_sequencer;

  localparam int WIDTH = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic             start, stop, hold, cont;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] q;
  logic             busy, done, wrap;
  logic [1:0]       state;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model: 0=IDLE 1=RUN 2=PAUSE 3=DONE
  int m_state, m_q, m_lim, m_mode, m_done, m_wrap;

  count_sequencer #(.WIDTH(WIDTH), .DEFAULT_LIMIT(999)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .hold(hold),
    .cont(cont), .limit(limit), .q(q), .busy(busy), .done(done),
    .wrap(wrap), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit st, sp, hd, ct;
    int lm;
    int e_state, e_q, e_busy, e_done, e_wrap;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_q = 0; m_lim = 999; m_mode = 0; m_done = 0; m_wrap = 0;
  endtask

  // One clock edge of the command rules, applied to the current inputs.
  task automatic model_edge();
    bit run_now;
    run_now = 0;
    m_done = 0;
    m_wrap = 0;
    if (m_state == 0) begin
      m_q = 0;
      if (!stop && start) begin
        m_lim = int'(limit); m_mode = int'(cont); m_state = 1;
      end
    end else if (m_state == 3) begin
      if (stop) begin
        m_state = 0; m_q = 0;
      end else if (start) begin
        m_lim = int'(limit); m_mode = int'(cont); m_q = 0; m_state = 1;
      end
    end else begin
      if (stop) begin
        m_state = 0; m_q = 0;
      end else if (hold) m_state = 2;
      else begin
        m_state = 1; run_now = 1;
      end
    end
    if (run_now) begin
      if (m_q < m_lim) m_q = m_q + 1;
      else if (m_mode == 1) begin
        m_q = 0; m_wrap = 1;
      end else begin
        m_state = 3; m_done = 1;
      end
    end
  endtask

  task automatic drive(input bit st, input bit sp, input bit hd, input bit ct, input int lm);
    start = st; stop = sp; hold = hd; cont = ct; limit = WIDTH'(lm);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("state", int'(state), m_state);
    chk("q", int'(q), m_q);
    chk("busy", int'(busy), int'(m_state == 1 || m_state == 2));
    chk("done", int'(done), m_done);
    chk("wrap", int'(wrap), m_wrap);
  endtask

  initial begin
    int cnt, dones, wraps, at;
    //                  st sp hd ct lm   state q busy done wrap
    vecs[0]  = '{1, 0, 0, 0, 2,    1, 0, 1, 0, 0};
    vecs[1]  = '{0, 0, 0, 1, 7,    1, 1, 1, 0, 0};
    vecs[2]  = '{0, 0, 1, 0, 0,    2, 1, 1, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 0,    1, 2, 1, 0, 0};
    vecs[4]  = '{0, 0, 0, 0, 0,    3, 2, 0, 1, 0};
    vecs[5]  = '{0, 0, 0, 0, 0,    3, 2, 0, 0, 0};
    vecs[6]  = '{1, 0, 0, 1, 1,    1, 0, 1, 0, 0};
    vecs[7]  = '{1, 0, 0, 0, 0,    1, 1, 1, 0, 0};
    vecs[8]  = '{0, 0, 0, 0, 9,    1, 0, 1, 0, 1};
    vecs[9]  = '{1, 1, 0, 0, 5,    0, 0, 0, 0, 0};
    vecs[10] = '{1, 1, 0, 0, 5,    0, 0, 0, 0, 0};
    vecs[11] = '{1, 0, 1, 1, 0,    1, 0, 1, 0, 0};
    vecs[12] = '{0, 0, 0, 0, 4,    1, 0, 1, 0, 1};
    vecs[13] = '{0, 0, 1, 0, 0,    2, 0, 1, 0, 0};
    vecs[14] = '{0, 0, 0, 0, 0,    1, 0, 1, 0, 1};
    vecs[15] = '{0, 1, 0, 0, 0,    0, 0, 0, 0, 0};

    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    model_reset();
    #12;
    chk("rst_state", int'(state), 0);
    chk("rst_q", int'(q), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wrap", int'(wrap), 0);
    @(posedge clk); #3 reset = 1'b1;

    // directed vector table
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].st, vecs[i].sp, vecs[i].hd, vecs[i].ct, vecs[i].lm);
      step();
      chk($sformatf("vec%0d_state", i), int'(state), vecs[i].e_state);
      chk($sformatf("vec%0d_q", i), int'(q), vecs[i].e_q);
      chk($sformatf("vec%0d_busy", i), int'(busy), vecs[i].e_busy);
      chk($sformatf("vec%0d_done", i), int'(done), vecs[i].e_done);
      chk($sformatf("vec%0d_wrap", i), int'(wrap), vecs[i].e_wrap);
    end

    // one-shot to 999
    drive(1, 0, 0, 0, 999); step(); drive(0, 0, 0, 0, 0);
    for (int k = 1; k <= 999; k++) step();
    chk("t1_q999", int'(q), 999);
    step();
    chk("t1_state_done", int'(state), 3);
    chk("t1_done_pulse", int'(done), 1);
    chk("t1_busy_low", int'(busy), 0);
    step();
    chk("t1_done_clear", int'(done), 0);
    chk("t1_q_hold", int'(q), 999);

    // continuous limit 9 for 35 edges
    drive(1, 0, 0, 1, 9); step(); drive(0, 0, 0, 0, 0);
    wraps = 0; dones = 0; at = 0;
    for (int k = 1; k <= 35; k++) begin
      step();
      if (wrap) begin
        wraps++;
        if (wraps == 3) at = k;
      end
      if (done) dones++;
      chk("t2_q", int'(q), k % 10);
    end
    chk("t2_wraps", wraps, 3);
    chk("t2_third_wrap_edge", at, 30);
    chk("t2_dones", dones, 0);
    drive(0, 1, 0, 0, 0); step();

    // hold for 3 edges at q=5, limit 20
    drive(1, 0, 0, 0, 20); step(); drive(0, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) step();
    drive(0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t3_pause_state", int'(state), 2);
      chk("t3_pause_q", int'(q), 5);
    end
    drive(0, 0, 0, 0, 0); step();
    chk("t3_resume_q", int'(q), 6);
    cnt = 9; at = 0;
    while (at == 0 && cnt < 40) begin
      step(); cnt++;
      if (done) at = cnt;
    end
    chk("t3_done_edge", at, 24);

    // stop mid-run, start+stop, start+hold
    drive(1, 0, 0, 0, 999); step(); drive(0, 0, 0, 0, 0);
    for (int k = 1; k <= 500; k++) step();
    chk("t4_q500", int'(q), 500);
    drive(0, 1, 0, 0, 0); step();
    chk("t4_stop_state", int'(state), 0);
    chk("t4_stop_q", int'(q), 0);
    chk("t4_stop_done", int'(done), 0);
    drive(1, 1, 0, 0, 7); step();
    chk("t4_startstop", int'(state), 0);
    drive(1, 0, 1, 0, 7); step();
    chk("t4_starthold_state", int'(state), 1);
    chk("t4_starthold_q", int'(q), 0);
    drive(0, 1, 0, 0, 0); step();

    // asynchronous reset at q=300
    drive(1, 0, 0, 0, 999); step(); drive(0, 0, 0, 0, 0);
    for (int k = 1; k <= 300; k++) step();
    chk("t5_q300", int'(q), 300);
    #3 reset = 1'b0;
    #1;
    chk("t5_async_q", int'(q), 0);
    chk("t5_async_state", int'(state), 0);
    chk("t5_async_busy", int'(busy), 0);
    model_reset();
    @(posedge clk); #3 reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5_idle_q", int'(q), 0);
    end

    // limit 0 one-shot, then direct restart from DONE with limit 3
    drive(1, 0, 0, 0, 0); step(); drive(0, 0, 0, 0, 0);
    step();
    chk("t6_done0", int'(done), 1);
    chk("t6_state0", int'(state), 3);
    drive(1, 0, 0, 0, 3); step(); drive(0, 0, 0, 0, 0);
    chk("t6_restart_state", int'(state), 1);
    chk("t6_restart_q", int'(q), 0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("t6_q", int'(q), k);
    end
    step();
    chk("t6_done3", int'(done), 1);
    chk("t6_q_hold3", int'(q), 3);

    // randomized commands against the model
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom % 8) == 0, ($urandom % 40) == 0, ($urandom % 6) == 0,
            $urandom % 2,
            (($urandom % 16) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 12)));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
